// File: rtl/irq_pkg.sv
// irq_pkg: shared defaults and reset constants for the interrupt pending latch
package irq_pkg;
  localparam int N_DEF = 4;
  localparam int IDX_W_DEF = 2;
  localparam logic [N_DEF-1:0] EDGE_SEL_DEF = 4'b1111;
  localparam logic EN_RST = 1'b0;
  localparam logic PEND_RST = 1'b0;
endpackage

// File: rtl/irq_chan_cell.sv
// irq_chan_cell: one channel's edge detect, pending bit and sticky overflow bit
module irq_chan_cell
  import irq_pkg::*;
#(
  parameter logic EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack_hit,
  input  logic ovf_clr,
  output logic pending,
  output logic overflow
);
  logic req_q, rise, pend_nxt, ovf_nxt;
  assign rise = req & ~req_q;
  // a same-cycle ack loses to a new rise and also suppresses the overflow it would otherwise cause
  assign pend_nxt = EDGE ? (rise | (pending & ~ack_hit)) : req;
  assign ovf_nxt = (EDGE & rise & pending & ~ack_hit) | (overflow & ~ovf_clr);
  // previous-sample, pending and overflow state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_q <= 1'b0;
      pending <= PEND_RST;
      overflow <= 1'b0;
    end else begin
      req_q <= req;
      pending <= pend_nxt;
      overflow <= ovf_nxt;
    end
endmodule

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: level-held request capture ahead of the priority encoder (optional IRQ_REQ_SYNC_EN input synchronizer)
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter logic [N-1:0] EDGE_SEL = N'(EDGE_SEL_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic             en_we,
  input  logic [N-1:0]     en_in,
  input  logic             ack_valid,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             ovf_clr,
  output logic [N-1:0]     pend_out,
  output logic             irq_any,
  output logic [N-1:0]     en_out,
  output logic [N-1:0]     overflow
);
  logic [N-1:0] req_s, pending, en;
`ifdef IRQ_REQ_SYNC_EN
  logic [N-1:0] sync1;
  // two-flop synchronizer so req_in may be asynchronous to clk
  always_ff @(posedge clk or posedge rst)
    if (rst) {req_s, sync1} <= '0;
    else {req_s, sync1} <= {sync1, req_in};
`else
  assign req_s = req_in;
`endif
  // channel-enable register
  always_ff @(posedge clk or posedge rst)
    if (rst) en <= {N{EN_RST}};
    else if (en_we) en <= en_in;
  for (genvar i = 0; i < N; i++) begin : g_chan
    irq_chan_cell #(.EDGE(EDGE_SEL[i])) u_cell (
      .clk(clk),
      .rst(rst),
      .req(req_s[i]),
      .ack_hit(ack_valid && ack_idx == IDX_W'(i)),
      .ovf_clr(ovf_clr),
      .pending(pending[i]),
      .overflow(overflow[i])
    );
  end
  assign pend_out = pending & en;
  assign irq_any = |pend_out;
  assign en_out = en;
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: random and directed checks of an all-edge and a mixed edge/level instance against a rule-level model
module tb_irq_pending_latch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_in = '0, en_in = '0;
  logic en_we = 1'b0, ack_valid = 1'b0, ovf_clr = 1'b0;
  logic [1:0] ack_idx = '0;
  logic [3:0] pend_a, en_a, ovf_a, pend_b, en_b, ovf_b;
  logic irq_a, irq_b;
  int vectors = 0, miscompares = 0;
  logic [3:0] es [2];
  logic [3:0] m_pend [2];
  logic [3:0] m_ovf [2];
  logic [3:0] m_en, m_q, m_s1, m_s2;

  always #5 clk = ~clk;

  irq_pending_latch #(.EDGE_SEL(4'b1111)) dut_a (
    .clk(clk), .rst(rst), .req_in(req_in), .en_we(en_we), .en_in(en_in),
    .ack_valid(ack_valid), .ack_idx(ack_idx), .ovf_clr(ovf_clr),
    .pend_out(pend_a), .irq_any(irq_a), .en_out(en_a), .overflow(ovf_a));

  irq_pending_latch #(.EDGE_SEL(4'b0111)) dut_b (
    .clk(clk), .rst(rst), .req_in(req_in), .en_we(en_we), .en_in(en_in),
    .ack_valid(ack_valid), .ack_idx(ack_idx), .ovf_clr(ovf_clr),
    .pend_out(pend_b), .irq_any(irq_b), .en_out(en_b), .overflow(ovf_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = '0;
      m_ovf[k] = '0;
    end
    m_en = '0; m_q = '0; m_s1 = '0; m_s2 = '0;
  endtask

  task automatic model_clock();
    logic [3:0] seen;
    logic r, hit;
`ifdef IRQ_REQ_SYNC_EN
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = req_in;
`else
    seen = req_in;
`endif
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        if (es[k][i]) begin
          r = seen[i] && !m_q[i];
          hit = ack_valid && (int'(ack_idx) == i);
          m_ovf[k][i] = (r && m_pend[k][i] && !hit) || (m_ovf[k][i] && !ovf_clr);
          if (r) m_pend[k][i] = 1'b1;
          else if (hit) m_pend[k][i] = 1'b0;
        end else begin
          m_pend[k][i] = seen[i];
          m_ovf[k][i] = 1'b0;
        end
    m_q = seen;
    if (en_we) m_en = en_in;
  endtask

  task automatic compare_all(input string tag);
    check({tag, " a.pend_out"}, 32'(pend_a), 32'(m_pend[0] & m_en));
    check({tag, " a.irq_any"}, 32'(irq_a), 32'(|(m_pend[0] & m_en)));
    check({tag, " a.en_out"}, 32'(en_a), 32'(m_en));
    check({tag, " a.overflow"}, 32'(ovf_a), 32'(m_ovf[0]));
    check({tag, " b.pend_out"}, 32'(pend_b), 32'(m_pend[1] & m_en));
    check({tag, " b.irq_any"}, 32'(irq_b), 32'(|(m_pend[1] & m_en)));
    check({tag, " b.en_out"}, 32'(en_b), 32'(m_en));
    check({tag, " b.overflow"}, 32'(ovf_b), 32'(m_ovf[1]));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    compare_all(tag);
    req_in = '0; en_we = 1'b0; ack_valid = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    es[0] = 4'b1111;
    es[1] = 4'b0111;
    model_reset();
    #1 compare_all("reset");
    #2 rst = 1'b0;
    en_we = 1'b1; en_in = 4'hF; cyc("enable");
    req_in = 4'b0100; cyc("pulse2");
`ifndef IRQ_REQ_SYNC_EN
    check("pulse2 literal", 32'(pend_a), 32'h4);
`endif
    repeat (3) cyc("hold2");
    check("hold2 irq_any", 32'(irq_a), 32'h1);
    ack_valid = 1'b1; ack_idx = 2'd2; cyc("ack2");
    cyc("idle");
    req_in = 4'b0010; cyc("rise1");
    cyc("gap1");
    req_in = 4'b0010; cyc("rise1 again");
    cyc("ovf1 sticky");
    cyc("ovf1 sticky2");
`ifndef IRQ_REQ_SYNC_EN
    check("ovf1 literal", 32'(ovf_a), 32'h2);
`endif
    ovf_clr = 1'b1; cyc("ovf clear");
    req_in = 4'b0010; cyc("gap");
    cyc("gap");
    req_in = 4'b0010; ovf_clr = 1'b1;
`ifdef IRQ_REQ_SYNC_EN
    cyc("pre"); cyc("pre"); ovf_clr = 1'b1;
`endif
    cyc("rise with ovf_clr");
    req_in = 4'b1000; cyc("rise3");
    cyc("gap3");
    req_in = 4'b1000; ack_valid = 1'b1; ack_idx = 2'd3;
`ifdef IRQ_REQ_SYNC_EN
    cyc("pre"); cyc("pre"); ack_valid = 1'b1; ack_idx = 2'd3;
`endif
    cyc("rise3 with ack3");
    repeat (3) cyc("settle");
    ack_valid = 1'b1; ack_idx = 2'd3; cyc("flush3");
    ack_valid = 1'b1; ack_idx = 2'd1; cyc("flush1");
    en_we = 1'b1; en_in = 4'b0000; cyc("disable");
    req_in = 4'b0001; cyc("masked0");
    repeat (3) cyc("masked0 hold");
    check("masked0 pend_out", 32'(pend_a), 32'h0);
    en_we = 1'b1; en_in = 4'b0001; cyc("expose0");
    check("expose0 pend_out", 32'(pend_a), 32'h1);
    en_we = 1'b1; en_in = 4'hF; cyc("enable all");
    for (int n = 0; n < 5; n++) begin
      req_in = 4'b1000;
      if (n == 2) begin ack_valid = 1'b1; ack_idx = 2'd3; end
      cyc("level3 held");
    end
    repeat (4) cyc("level3 release");
    check("level3 dropped", 32'(pend_b[3]), 32'h0);
    req_in = 4'b1010; cyc("setup a");
    cyc("setup b");
    req_in = 4'b1000; cyc("setup c");
    repeat (2) cyc("setup d");
    async_reset("async reset");
    check("async reset literal", 32'({pend_a, ovf_a, en_a, irq_a}), 32'h0);
    for (int n = 0; n < 600; n++) begin
      req_in = 4'($urandom);
      en_we = ($urandom_range(0, 9) == 0);
      en_in = 4'($urandom);
      ack_valid = $urandom_range(0, 1) == 1;
      ack_idx = 2'($urandom);
      ovf_clr = ($urandom_range(0, 7) == 0);
      cyc("random");
      if (n == 300) async_reset("random async reset");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
